multicycle_control: RTL

- Moore-style control FSM for the multicycle CPU.
- Produces IRWrite and all datapath enables. Consumes the latched OPcode from the instruction decoder, which in turn depends on IRWrite.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB for R-type, LW, SW, BEQ, J and ADDI.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_pkg.sv | 43 ++++
 rtl/control_out_decode.sv | 65 ++++++
 rtl/multicycle_control.sv | 81 ++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state encodings, opcodes, datapath select codes and control word for the multicycle CPU control.
package multicycle_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  // ir_write/pc_write in FETCH and done in MEM_WRITE are still qualified by mem_ready in the top.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
  } ctrl_t;
  function automatic logic legal_op(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction
endpackage

// File: rtl/control_out_decode.sv
// control_out_decode: combinational state -> control word map.
// Ports: state (current FSM state, 4 bits) in; ctrl (raw control word) out.
module control_out_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ITYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.done       = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.done          = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
        ctrl.done      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multicycle CPU with memory-ready stalls and a retired-instruction counter.
// Ports: clk, rst_n (async active-low); OPcode, Zero, mem_ready in; datapath enables/selects,
// state (debug), instr_done and illegal_op pulses, retired count out.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OPcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  state_t cur, nxt;
  ctrl_t  c;
  // Zero is consumed by the datapath together with PCWriteCond; the FSM never branches on it.
  logic unused_zero;
  assign unused_zero = Zero;
  control_out_decode u_dec (.state(cur), .ctrl(c));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      retired <= '0;
    end else begin
      cur     <= nxt;
      retired <= retired + CNT_W'(instr_done);
    end
  end
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:     nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    nxt = OPcode == OP_R                      ? S_EXEC_R   :
                         (OPcode == OP_LW || OPcode == OP_SW) ? S_MEM_ADDR :
                         OPcode == OP_BEQ                    ? S_BRANCH   :
                         OPcode == OP_J                      ? S_JUMP     :
                         OPcode == OP_ADDI                   ? S_EXEC_I   : S_FETCH;
      S_EXEC_R:    nxt = S_RTYPE_WB;
      S_EXEC_I:    nxt = S_ITYPE_WB;
      S_MEM_ADDR:  nxt = OPcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
      default:     nxt = S_FETCH;
    endcase
  end
  // The fetch-side writes and the store completion only happen once memory answers.
  assign IRWrite     = c.ir_write & mem_ready;
  assign PCWrite     = c.pc_write & (cur != S_FETCH || mem_ready);
  assign instr_done  = c.done & (cur != S_MEM_WRITE || mem_ready);
  assign illegal_op  = cur == S_DECODE && !legal_op(OPcode);
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.iord;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign MemtoReg    = c.mem_to_reg;
  assign RegDst      = c.reg_dst;
  assign RegWrite    = c.reg_write;
  assign ALUSrcA     = c.alu_src_a;
  assign ALUSrcB     = c.alu_src_b;
  assign ALUOp       = c.alu_op;
  assign PCSource    = c.pc_source;
  assign state       = cur;
endmodule
